// File: rtl/counter_b4_ctrl_if.sv
// Command handshake between the host/stimulus logic and counter_b4_ctrl.
// The host drives a command with cmd_valid; the controller raises cmd_ready only while idle.
interface counter_b4_ctrl_if #(
  parameter int WRAP_W = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_mode;
  logic [3:0]        cmd_D;
  logic [WRAP_W-1:0] cmd_wraps;
  logic              cmd_abort;

  modport master (
    output cmd_valid, cmd_mode, cmd_D, cmd_wraps, cmd_abort,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_D, cmd_wraps, cmd_abort,
    output cmd_ready
  );
endinterface

// File: rtl/counter_b4_ctrl.sv
// Command sequencer for the 4-bit mode counter: preload, run for N rco events, report done/errors.
// Optional watchdog enabled by defining COUNTER_B4_CTRL_TIMEOUT_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for a command, cmd_ready=1
// LOAD     | one cycle of parallel load (enable=1, mode=11, D=start)
// LOAD_ACK | waiting for b4_load, then check b4_Q against start value
// RUN      | counter enabled in the requested mode, counting rco pulses
// DONE     | one-cycle completion pulse
module counter_b4_ctrl #(
  parameter int WRAP_W      = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             b4_clk,
  input  logic             b4_reset,
  counter_b4_ctrl_if.slave cmd,
  input  logic             err_clr,
  input  logic             b4_load,
  input  logic             b4_rco,
  input  logic [3:0]       b4_Q,
  output logic             b4_enable,
  output logic [1:0]       b4_mode,
  output logic [3:0]       b4_D,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             err_load,
  output logic             err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LOAD_ACK,
    S_RUN,
    S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [1:0]        mode_q;
  logic [WRAP_W-1:0] wraps_q;
  logic [WRAP_W-1:0] rco_cnt, rco_cnt_nxt, rco_inc;
  logic              capture, abort_hit, load_err_set;

  if (WRAP_W < 1 || TIMEOUT_CYC < 2) begin : g_param_check
    $error("counter_b4_ctrl: WRAP_W must be >= 1 and TIMEOUT_CYC >= 2");
  end

  assign cmd.cmd_ready = (state == S_IDLE);
  assign rco_inc       = rco_cnt + WRAP_W'(1);

`ifdef COUNTER_B4_CTRL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_hit, timeout_set, wd_waiting;

  assign wd_waiting = (state == S_LOAD_ACK) || (state == S_RUN);
  assign wd_hit     = (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge b4_clk or negedge b4_reset) begin
    if (!b4_reset) begin
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (!wd_waiting || state_nxt != state || (state == S_RUN && b4_rco))
        wd_cnt <= '0;
      else
        wd_cnt <= wd_cnt + WD_W'(1);
      if (timeout_set)
        err_timeout <= 1'b1;
      else if (err_clr)
        err_timeout <= 1'b0;
    end
  end
`else
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    rco_cnt_nxt  = rco_cnt;
    capture      = 1'b0;
    abort_hit    = 1'b0;
    load_err_set = 1'b0;
`ifdef COUNTER_B4_CTRL_TIMEOUT_EN
    timeout_set  = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (cmd.cmd_valid) begin
          capture   = 1'b1;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: state_nxt = S_LOAD_ACK;
      S_LOAD_ACK: begin
        if (b4_load) begin
          load_err_set = (b4_Q != b4_D);
          if (mode_q == 2'b11 || wraps_q == '0)
            state_nxt = S_DONE;
          else
            state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        // count is compared after increment so DONE follows the last rco directly
        if (b4_rco) begin
          rco_cnt_nxt = rco_inc;
          if (rco_inc == wraps_q)
            state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        rco_cnt_nxt = '0;
        state_nxt   = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
`ifdef COUNTER_B4_CTRL_TIMEOUT_EN
    if (wd_waiting && state_nxt == state && !(state == S_RUN && b4_rco) && wd_hit) begin
      timeout_set = 1'b1;
      state_nxt   = S_DONE;
    end
`endif
    // abort cancels the command outright, including any error found this cycle
    if (state != S_IDLE && cmd.cmd_abort) begin
      state_nxt    = S_IDLE;
      rco_cnt_nxt  = '0;
      abort_hit    = 1'b1;
      load_err_set = 1'b0;
`ifdef COUNTER_B4_CTRL_TIMEOUT_EN
      timeout_set  = 1'b0;
`endif
    end
  end

  always_ff @(posedge b4_clk or negedge b4_reset) begin
    if (!b4_reset) begin
      state     <= S_IDLE;
      mode_q    <= 2'b00;
      wraps_q   <= '0;
      rco_cnt   <= '0;
      b4_enable <= 1'b0;
      b4_mode   <= 2'b00;
      b4_D      <= 4'h0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      err_load  <= 1'b0;
    end else begin
      state   <= state_nxt;
      rco_cnt <= rco_cnt_nxt;
      if (capture) begin
        mode_q  <= cmd.cmd_mode;
        wraps_q <= cmd.cmd_wraps;
        b4_D    <= cmd.cmd_D;
      end
      b4_enable <= (state_nxt == S_LOAD) || (state_nxt == S_RUN);
      if (state_nxt == S_LOAD)
        b4_mode <= 2'b11;
      else if (state_nxt == S_RUN)
        b4_mode <= mode_q;
      busy    <= (state_nxt != S_IDLE);
      done    <= (state_nxt == S_DONE);
      aborted <= abort_hit;
      if (load_err_set)
        err_load <= 1'b1;
      else if (err_clr)
        err_load <= 1'b0;
    end
  end

endmodule

// File: tb/tb_counter_b4_ctrl.sv
// Directed bench for counter_b4_ctrl; watchdog expectations follow COUNTER_B4_CTRL_TIMEOUT_EN.
module tb_counter_b4_ctrl;
  logic       b4_clk;
  logic       b4_reset;
  logic       err_clr, b4_load, b4_rco;
  logic [3:0] b4_Q;
  logic       b4_enable;
  logic [1:0] b4_mode;
  logic [3:0] b4_D;
  logic       busy, done, aborted, err_load, err_timeout;

  int total = 0;
  int bad   = 0;

  counter_b4_ctrl_if #(.WRAP_W(4)) cif ();

  counter_b4_ctrl #(.WRAP_W(4), .TIMEOUT_CYC(64)) dut (
    .b4_clk      (b4_clk),
    .b4_reset    (b4_reset),
    .cmd         (cif),
    .err_clr     (err_clr),
    .b4_load     (b4_load),
    .b4_rco      (b4_rco),
    .b4_Q        (b4_Q),
    .b4_enable   (b4_enable),
    .b4_mode     (b4_mode),
    .b4_D        (b4_D),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .err_load    (err_load),
    .err_timeout (err_timeout)
  );

  initial b4_clk = 1'b0;
  always #5 b4_clk = ~b4_clk;

  task automatic step();
    @(posedge b4_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] m, input logic [3:0] d, input logic [3:0] w);
    cif.cmd_mode  = m;
    cif.cmd_D     = d;
    cif.cmd_wraps = w;
    cif.cmd_valid = 1'b1;
    step();
    cif.cmd_valid = 1'b0;
  endtask

  initial begin
    b4_reset = 1'b0;
    err_clr = 1'b0; b4_load = 1'b0; b4_rco = 1'b0; b4_Q = 4'h0;
    cif.cmd_valid = 1'b0; cif.cmd_mode = 2'b00; cif.cmd_D = 4'h0;
    cif.cmd_wraps = 4'h0; cif.cmd_abort = 1'b0;
    repeat (2) step();
    chk("rst_enable", 8'(b4_enable), 8'h0);
    chk("rst_mode", 8'(b4_mode), 8'h0);
    chk("rst_D", 8'(b4_D), 8'h0);
    chk("rst_busy", 8'(busy), 8'h0);
    chk("rst_flags", 8'({done, aborted, err_load, err_timeout}), 8'h0);
    b4_reset = 1'b1;
    step();
    chk("rst_ready", 8'(cif.cmd_ready), 8'h1);

    // load-only command: mode 11 never enters RUN
    issue(2'b11, 4'hA, 4'd3);
    chk("ld_enable", 8'(b4_enable), 8'h1);
    chk("ld_mode", 8'(b4_mode), 8'h3);
    chk("ld_D", 8'(b4_D), 8'hA);
    chk("ld_busy", 8'(busy), 8'h1);
    chk("ld_ready", 8'(cif.cmd_ready), 8'h0);
    step();
    chk("ldack_enable", 8'(b4_enable), 8'h0);
    b4_load = 1'b1; b4_Q = 4'hA;
    step();
    b4_load = 1'b0;
    chk("ldonly_done", 8'(done), 8'h1);
    chk("ldonly_enable", 8'(b4_enable), 8'h0);
    chk("ldonly_err", 8'(err_load), 8'h0);
    step();
    chk("ldonly_idle", 8'({done, busy, cif.cmd_ready}), 8'h1);

    // mode 00, two wraps
    issue(2'b00, 4'h1, 4'd2);
    chk("r2_ld_D", 8'(b4_D), 8'h1);
    step();
    b4_load = 1'b1; b4_Q = 4'h1;
    step();
    b4_load = 1'b0;
    chk("r2_run_en", 8'(b4_enable), 8'h1);
    chk("r2_run_mode", 8'(b4_mode), 8'h0);
    b4_rco = 1'b1;
    step();
    b4_rco = 1'b0;
    chk("r2_rco1_done", 8'(done), 8'h0);
    chk("r2_rco1_en", 8'(b4_enable), 8'h1);
    step();
    chk("r2_gap_en", 8'(b4_enable), 8'h1);
    b4_rco = 1'b1;
    step();
    b4_rco = 1'b0;
    chk("r2_done", 8'(done), 8'h1);
    chk("r2_done_en", 8'(b4_enable), 8'h0);
    step();
    chk("r2_after", 8'({done, b4_enable, busy}), 8'h0);

    // load mismatch, sticky through next command, then cleared
    issue(2'b01, 4'hF, 4'd1);
    step();
    b4_load = 1'b1; b4_Q = 4'hE;
    step();
    b4_load = 1'b0;
    chk("mm_err", 8'(err_load), 8'h1);
    chk("mm_run_mode", 8'(b4_mode), 8'h1);
    b4_rco = 1'b1;
    step();
    b4_rco = 1'b0;
    chk("mm_done", 8'(done), 8'h1);
    step();
    issue(2'b11, 4'h3, 4'd0);
    step();
    b4_load = 1'b1; b4_Q = 4'h3;
    step();
    b4_load = 1'b0;
    chk("mm_sticky", 8'(err_load), 8'h1);
    chk("mm_w0_done", 8'(done), 8'h1);
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("mm_clr", 8'(err_load), 8'h0);
    issue(2'b11, 4'h7, 4'd0);
    step();
    b4_load = 1'b1; b4_Q = 4'h6; err_clr = 1'b1;
    step();
    b4_load = 1'b0; err_clr = 1'b0;
    chk("mm_err_wins", 8'(err_load), 8'h1);
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;

    // abort in RUN after one rco
    issue(2'b10, 4'h5, 4'd5);
    step();
    b4_load = 1'b1; b4_Q = 4'h5;
    step();
    b4_load = 1'b0;
    chk("ab_run_mode", 8'(b4_mode), 8'h2);
    b4_rco = 1'b1;
    step();
    b4_rco = 1'b0; cif.cmd_abort = 1'b1;
    step();
    cif.cmd_abort = 1'b0;
    chk("ab_flags", 8'({b4_enable, aborted, done, busy}), 8'h4);
    chk("ab_ready", 8'(cif.cmd_ready), 8'h1);
    step();
    chk("ab_pulse_end", 8'(aborted), 8'h0);
    cif.cmd_abort = 1'b1;
    step();
    cif.cmd_abort = 1'b0;
    chk("ab_idle_ignored", 8'({aborted, cif.cmd_ready}), 8'h1);
    // counter restarted from 0; rco during LOAD_ACK must not count
    issue(2'b01, 4'h2, 4'd1);
    step();
    b4_rco = 1'b1;
    step();
    b4_rco = 1'b0;
    chk("ab_ldack_rco", 8'({b4_enable, busy}), 8'h1);
    b4_load = 1'b1; b4_Q = 4'h2;
    step();
    b4_load = 1'b0;
    chk("ab_run2_en", 8'(b4_enable), 8'h1);
    b4_rco = 1'b1;
    step();
    b4_rco = 1'b0;
    chk("ab_cnt_restart", 8'(done), 8'h1);
    step();

    // watchdog: b4_load never arrives
    issue(2'b00, 4'h0, 4'd1);
    step();
    repeat (63) step();
    chk("wd_pre", 8'({done, err_timeout}), 8'h0);
    step();
`ifdef COUNTER_B4_CTRL_TIMEOUT_EN
    chk("wd_done", 8'({done, err_timeout, b4_enable}), 8'h6);
    step();
    chk("wd_idle", 8'({busy, err_timeout}), 8'h1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("wd_clr", 8'(err_timeout), 8'h0);
`else
    chk("wd_none", 8'({done, busy, err_timeout}), 8'h2);
    repeat (100) step();
    chk("wd_none_long", 8'({done, busy, err_timeout}), 8'h2);
    cif.cmd_abort = 1'b1;
    step();
    cif.cmd_abort = 1'b0;
    chk("wd_none_abort", 8'({aborted, busy}), 8'h2);
`endif
    step();

    // asynchronous reset while running
    issue(2'b01, 4'h4, 4'd3);
    step();
    b4_load = 1'b1; b4_Q = 4'h4;
    step();
    b4_load = 1'b0;
    chk("ar_run_en", 8'(b4_enable), 8'h1);
    #3;
    b4_reset = 1'b0;
    #1;
    chk("ar_async", 8'({b4_enable, busy, cif.cmd_ready}), 8'h1);
    step();
    b4_reset = 1'b1;
    step();
    chk("ar_release", 8'({b4_enable, busy, cif.cmd_ready}), 8'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
